elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised pipeline stage register. Successor to the fixed-field enable/flush stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque DATA_W-bit payload (packed stage fields) plus a halt tag.
- Uses a valid/ready handshake instead of global enable. An optional 2-entry skid buffer gives a registered in_ready, cutting the stall path.
- Sticky halt output replaces the per-stage halt flop.

Parameters:
- DATA_W, 32, payload width in bits (packed stage struct width, >=1).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- in_halt  input  1  entry carries halt tag.
- flush  input  1  discard all held entries at next edge.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  head payload.
- out_halt  output  1  head entry's halt tag.
- halt  output  1  sticky: a halt-tagged entry has been consumed.
- count  output  2  entries held (0..2).

Behaviour:
- Reset (nRST=0, async): state EMPTY, main/skid data and tags cleared to 0, halt=0, count=0, out_valid=0, out_data=0, out_halt=0. in_ready=0 while nRST low, then 1 from the first edge after release.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both sides must hold valid/data stable until accepted; the stage never drops or duplicates an accepted entry except on flush.
- States: EMPTY (count 0), FULL (count 1, main reg), SKID (count 2, main + skid; reachable only when SKID=1).
- Transitions, absent flush:
  - EMPTY: push -> FULL, main<=in. Otherwise stay.
  - FULL: push&pop -> FULL, main<=in. push&!pop -> SKID, skid<=in. !push&pop -> EMPTY. Neither -> stay.
  - SKID: in_ready=0, so no push. pop -> FULL, main<=skid. Otherwise stay.
- Outputs from state:
  - out_valid = (state!=EMPTY) & !halt.
  - out_data/out_halt always driven from main.
- in_ready:
  - SKID=1: registered; = (next_state!=SKID) & !next_halt.
  - SKID=0: combinational; = (state==EMPTY | out_ready) & !halt.
- Latency: one cycle from push to out_valid. Throughput one entry/cycle in both modes.
- Flush:
  - At the edge, state->EMPTY and count->0. Data regs are not cleared.
  - A push in a flush cycle is discarded.
  - A pop in a flush cycle is a legal consume, including halt setting.
  - Flush wins over every simultaneous event.
- Halt:
  - halt sets at the edge where pop occurs with out_halt=1. Cleared only by nRST; unaffected by flush.
  - Once set: out_valid=0 and in_ready=0 permanently. Any entry left in skid is frozen.
- Reset mid-operation: held entries are lost; outputs return to reset values asynchronously.
- Width rules: payload passes bit-exact. count is 2 bits and saturates structurally at 2, since SKID is unreachable when SKID=0.

Decomposition:
- cpu_types_pkg gains typedef pipe_state_t enum logic[1:0] {EMPTY=2'b00, FULL=2'b01, SKIDDED=2'b10}.
- Stage-specific packed payload structs (e.g. mem_wb payload) belong in data_path_muxs_pkg, or a new pipe_payload_pkg, so DATA_W is derived with $bits.
- Companion interface elastic_pipe_reg_if (parametrised by DATA_W) with modports for stage, upstream and downstream.
- No sub-module: state, next-state and two data registers fit in one module.

Test Plan:
- Reset/idle: nRST=0 mid-run with count=2 -> immediately out_valid=0, count=0, out_data=0, halt=0. After release, in_ready=1 at the first edge.
- Streaming: SKID=1, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles +1..+3, count stays 1, in_ready stays 1.
- Backpressure: out_ready=0, push 0xA, 0xB -> count=2, in_ready=0 next cycle. Extra in_valid with 0xC is not accepted. Release out_ready -> pops 0xA, 0xB, then 0xC pushed in order.
- Flush: count=2 holding 0x5, 0x6, assert flush with in_valid (0x7) and out_ready=1 -> 0x5 consumed, next cycle count=0, out_valid=0, 0x6 and 0x7 lost.
- Halt: push 0x1 (halt=0), 0x2 (halt=1), 0x3 with out_ready=1 -> halt rises the edge after 0x2 pops; out_valid and in_ready stay 0; 0x3 never appears; flush does not clear halt.
- SKID=0 variant: out_ready=0 with count=1 -> in_ready=0 the same cycle. out_ready=1 plus in_valid -> simultaneous push/pop, count stays 1, never reaches 2.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// rtl/elastic_pipe_reg_pkg.sv - state type and occupancy helper for the elastic pipeline stage
package elastic_pipe_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FULL    = 2'b01,
    SKIDDED = 2'b10
  } pipe_state_t;

  localparam int COUNT_W = 2;

  function automatic logic [COUNT_W-1:0] state_count(input pipe_state_t s);
    case (s)
      FULL:    return 2'd1;
      SKIDDED: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// rtl/elastic_pipe_reg_if.sv - valid/ready stage bus with stage, upstream and downstream views
interface elastic_pipe_reg_if #(
  parameter int DATA_W = 32
);
  import elastic_pipe_reg_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_halt;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_halt;
  logic                halt;
  logic [COUNT_W-1:0]  count;

  modport stage (
    input  in_valid, in_data, in_halt, flush, out_ready,
    output in_ready, out_valid, out_data, out_halt, halt, count
  );

  modport upstream (
    output in_valid, in_data, in_halt, flush,
    input  in_ready, halt
  );

  modport downstream (
    input  out_valid, out_data, out_halt, halt, count,
    output out_ready
  );

endinterface

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - valid/ready pipeline stage register with optional skid entry and sticky halt
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  elastic_pipe_reg_if.stage bus
);

  pipe_state_t       state;
  pipe_state_t       next_state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_halt;
  logic              skid_halt;
  logic              halt_q;
  logic              next_halt;
  logic              ready_q;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign out_valid     = (state != EMPTY) && !halt_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data;
  assign bus.out_halt  = main_halt;
  assign bus.halt      = halt_q;
  assign bus.count     = state_count(state);
  assign bus.in_ready  = in_ready;

  // ready_q doubles as an "out of reset" flag in the single-register mode.
  assign in_ready  = SKID ? ready_q
                          : (ready_q && (state == EMPTY || bus.out_ready) && !halt_q);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign next_halt = halt_q || (pop && main_halt);

  always_comb begin
    next_state = state;
    if (bus.flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) next_state = FULL;
        FULL: begin
          if (push && !pop && SKID) next_state = SKIDDED;
          else if (!push && pop)    next_state = EMPTY;
        end
        SKIDDED: if (pop) next_state = FULL;
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      main_data <= '0;
      main_halt <= 1'b0;
      skid_data <= '0;
      skid_halt <= 1'b0;
      halt_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state   <= next_state;
      halt_q  <= next_halt;
      ready_q <= SKID ? ((next_state != SKIDDED) && !next_halt) : 1'b1;
      // Flush only drops occupancy; payload registers keep their contents.
      if (!bus.flush) begin
        if (push && (state == EMPTY || pop)) begin
          main_data <= bus.in_data;
          main_halt <= bus.in_halt;
        end else if (state == SKIDDED && pop) begin
          main_data <= skid_data;
          main_halt <= skid_halt;
        end
        if (push && state == FULL && !pop) begin
          skid_data <= bus.in_data;
          skid_halt <= bus.in_halt;
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - bench for elastic_pipe_reg, both SKID variants against a FIFO model
module tb_elastic_pipe_reg;

  localparam int DW = 16;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  elastic_pipe_reg_if #(.DATA_W(DW)) b0 ();
  elastic_pipe_reg_if #(.DATA_W(DW)) b1 ();

  elastic_pipe_reg #(.DATA_W(DW), .SKID(1'b0)) dut0 (.CLK(CLK), .nRST(nRST), .bus(b0));
  elastic_pipe_reg #(.DATA_W(DW), .SKID(1'b1)) dut1 (.CLK(CLK), .nRST(nRST), .bus(b1));

  logic          s_valid [2];
  logic [DW-1:0] s_data  [2];
  logic          s_halt  [2];
  logic          s_flush [2];
  logic          s_ordy  [2];

  assign b0.in_valid  = s_valid[0];
  assign b0.in_data   = s_data[0];
  assign b0.in_halt   = s_halt[0];
  assign b0.flush     = s_flush[0];
  assign b0.out_ready = s_ordy[0];
  assign b1.in_valid  = s_valid[1];
  assign b1.in_data   = s_data[1];
  assign b1.in_halt   = s_halt[1];
  assign b1.flush     = s_flush[1];
  assign b1.out_ready = s_ordy[1];

  logic          d_ov  [2];
  logic          d_ir  [2];
  logic          d_oh  [2];
  logic          d_ht  [2];
  logic [1:0]    d_cnt [2];
  logic [DW-1:0] d_od  [2];

  assign d_ov[0]  = b0.out_valid;
  assign d_ir[0]  = b0.in_ready;
  assign d_oh[0]  = b0.out_halt;
  assign d_ht[0]  = b0.halt;
  assign d_cnt[0] = b0.count;
  assign d_od[0]  = b0.out_data;
  assign d_ov[1]  = b1.out_valid;
  assign d_ir[1]  = b1.in_ready;
  assign d_oh[1]  = b1.out_halt;
  assign d_ht[1]  = b1.halt;
  assign d_cnt[1] = b1.count;
  assign d_od[1]  = b1.out_data;

  // Model: an ordered list of held entries (capacity 2 with skid, 1 without) plus a halt flag.
  int            m_n     [2];
  logic [DW-1:0] m_d     [2][2];
  logic          m_h     [2][2];
  logic          m_halt  [2];
  logic          m_rdy   [2];
  logic          m_alive [2];
  logic          m_push  [2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut_skid%0d t=%0t got=%0h expected=%0h", nm, k, $time, got, exp);
    end
  endtask

  logic e_ov, e_ir, p_push, p_pop;

  always @(negedge CLK) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!nRST) begin
        chk("rst_out_valid", k, d_ov[k], 0);
        chk("rst_count", k, d_cnt[k], 0);
        chk("rst_out_data", k, d_od[k], 0);
        chk("rst_out_halt", k, d_oh[k], 0);
        chk("rst_halt", k, d_ht[k], 0);
        chk("rst_in_ready", k, d_ir[k], 0);
        m_n[k]     = 0;
        m_halt[k]  = 1'b0;
        m_rdy[k]   = 1'b0;
        m_alive[k] = 1'b0;
        m_push[k]  = 1'b0;
      end else begin
        e_ov = (m_n[k] > 0) && !m_halt[k];
        e_ir = (k == 1) ? m_rdy[k]
                        : (m_alive[k] && !m_halt[k] && (m_n[k] == 0 || s_ordy[k]));
        chk("out_valid", k, d_ov[k], e_ov);
        chk("in_ready", k, d_ir[k], e_ir);
        chk("count", k, d_cnt[k], m_n[k]);
        chk("halt", k, d_ht[k], m_halt[k]);
        if (e_ov) begin
          chk("out_data", k, d_od[k], m_d[k][0]);
          chk("out_halt", k, d_oh[k], m_h[k][0]);
        end
        p_push = s_valid[k] && e_ir;
        p_pop  = e_ov && s_ordy[k];
        if (p_pop) begin
          if (m_h[k][0]) m_halt[k] = 1'b1;
          m_d[k][0] = m_d[k][1];
          m_h[k][0] = m_h[k][1];
          m_n[k]--;
        end
        if (s_flush[k]) begin
          m_n[k] = 0;
        end else if (p_push && m_n[k] < 2) begin
          m_d[k][m_n[k]] = s_data[k];
          m_h[k][m_n[k]] = s_halt[k];
          m_n[k]++;
        end
        m_alive[k] = 1'b1;
        m_rdy[k]   = (m_n[k] < 2) && !m_halt[k];
        m_push[k]  = p_push;
      end
    end
  end

  task automatic drive(input int k, input logic v, input logic [DW-1:0] d, input logic h,
                       input logic f, input logic r);
    @(negedge CLK);
    s_valid[k] = v;
    s_data[k]  = d;
    s_halt[k]  = h;
    s_flush[k] = f;
    s_ordy[k]  = r;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 1'b0;
      s_data[k]  = '0;
      s_halt[k]  = 1'b0;
      s_flush[k] = 1'b0;
      s_ordy[k]  = 1'b0;
    end
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    #2 chk("ready_before_first_edge", 1, d_ir[1], 0);
    @(negedge CLK);
    #2 chk("ready_after_first_edge", 1, d_ir[1], 1);
    chk("ready_after_first_edge", 0, d_ir[0], 1);

    // streaming, skid variant
    drive(1, 1, 16'h11, 0, 0, 1);
    drive(1, 1, 16'h22, 0, 0, 1); #2 chk("stream_d11", 1, d_od[1], 16'h11);
    chk("stream_cnt", 1, d_cnt[1], 1);
    chk("stream_rdy", 1, d_ir[1], 1);
    drive(1, 1, 16'h33, 0, 0, 1); #2 chk("stream_d22", 1, d_od[1], 16'h22);
    drive(1, 0, 16'h0, 0, 0, 1);  #2 chk("stream_d33", 1, d_od[1], 16'h33);
    chk("stream_cnt3", 1, d_cnt[1], 1);
    drive(1, 0, 16'h0, 0, 0, 0);  #2 chk("stream_empty", 1, d_cnt[1], 0);

    // backpressure
    drive(1, 1, 16'hA, 0, 0, 0);
    drive(1, 1, 16'hB, 0, 0, 0); #2 chk("bp_cnt1", 1, d_cnt[1], 1);
    drive(1, 1, 16'hC, 0, 0, 0); #2 chk("bp_cnt2", 1, d_cnt[1], 2);
    chk("bp_rdy0", 1, d_ir[1], 0);
    drive(1, 1, 16'hC, 0, 0, 0); #2 chk("bp_c_blocked", 1, d_cnt[1], 2);
    drive(1, 1, 16'hC, 0, 0, 1); #2 chk("bp_pop_a", 1, d_od[1], 16'hA);
    drive(1, 1, 16'hC, 0, 0, 1); #2 chk("bp_pop_b", 1, d_od[1], 16'hB);
    chk("bp_rdy1", 1, d_ir[1], 1);
    drive(1, 0, 16'h0, 0, 0, 1); #2 chk("bp_pop_c", 1, d_od[1], 16'hC);
    chk("bp_cnt_c", 1, d_cnt[1], 1);
    drive(1, 0, 16'h0, 0, 0, 0); #2 chk("bp_drained", 1, d_cnt[1], 0);

    // flush with count 2, simultaneous push and pop
    drive(1, 1, 16'h5, 0, 0, 0);
    drive(1, 1, 16'h6, 0, 0, 0);
    drive(1, 1, 16'h7, 0, 1, 1); #2 chk("flush_head", 1, d_od[1], 16'h5);
    chk("flush_cnt_before", 1, d_cnt[1], 2);
    drive(1, 0, 16'h0, 0, 0, 0); #2 chk("flush_cnt", 1, d_cnt[1], 0);
    chk("flush_ov", 1, d_ov[1], 0);

    // asynchronous reset while holding two entries
    drive(1, 1, 16'h8, 0, 0, 0);
    drive(1, 1, 16'h9, 0, 0, 0);
    drive(1, 0, 16'h0, 0, 0, 0); #2 chk("prerst_cnt", 1, d_cnt[1], 2);
    #1 nRST = 1'b0;
    #1 chk("async_rst_ov", 1, d_ov[1], 0);
    chk("async_rst_cnt", 1, d_cnt[1], 0);
    chk("async_rst_data", 1, d_od[1], 0);
    chk("async_rst_halt", 1, d_ht[1], 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #2 chk("rerst_rdy0", 1, d_ir[1], 0);
    @(negedge CLK);
    #2 chk("rerst_rdy1", 1, d_ir[1], 1);

    // single-register variant: combinational ready, never two entries
    drive(0, 1, 16'h44, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 0);  #2 chk("s0_cnt1", 0, d_cnt[0], 1);
    chk("s0_rdy_stall", 0, d_ir[0], 0);
    drive(0, 1, 16'h55, 0, 0, 1); #2 chk("s0_rdy_comb", 0, d_ir[0], 1);
    chk("s0_d44", 0, d_od[0], 16'h44);
    drive(0, 1, 16'h66, 0, 0, 1); #2 chk("s0_d55", 0, d_od[0], 16'h55);
    chk("s0_cnt_pp", 0, d_cnt[0], 1);
    drive(0, 0, 16'h0, 0, 0, 1);  #2 chk("s0_d66", 0, d_od[0], 16'h66);
    drive(0, 0, 16'h0, 0, 0, 0);  #2 chk("s0_empty", 0, d_cnt[0], 0);

    // halt
    drive(1, 1, 16'h1, 0, 0, 1);
    drive(1, 1, 16'h2, 1, 0, 1); #2 chk("halt_d1", 1, d_od[1], 16'h1);
    drive(1, 1, 16'h3, 0, 0, 1); #2 chk("halt_d2", 1, d_od[1], 16'h2);
    chk("halt_tag", 1, d_oh[1], 1);
    chk("halt_not_yet", 1, d_ht[1], 0);
    drive(1, 0, 16'h0, 0, 0, 1); #2 chk("halt_set", 1, d_ht[1], 1);
    chk("halt_ov", 1, d_ov[1], 0);
    chk("halt_rdy", 1, d_ir[1], 0);
    drive(1, 0, 16'h0, 0, 1, 1);
    drive(1, 1, 16'h4, 0, 0, 1); #2 chk("halt_after_flush", 1, d_ht[1], 1);
    chk("halt_ov_after_flush", 1, d_ov[1], 0);
    drive(1, 0, 16'h0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // randomized traffic with periodic resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      nRST = (c % 300 != 299);
      for (int k = 0; k < 2; k++) begin
        if (!(s_valid[k] && !m_push[k])) begin
          s_valid[k] = ($urandom_range(0, 2) != 0);
          s_data[k]  = DW'($urandom());
          s_halt[k]  = ($urandom_range(0, 40) == 0);
        end
        s_ordy[k]  = ($urandom_range(0, 3) != 0);
        s_flush[k] = ($urandom_range(0, 30) == 0);
      end
    end
    @(negedge CLK);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
